addr4u_share_ctrl: RTL and testbench

//  Shares one external combinational 4-bit unsigned adder (addr4u_* family) between NREQ requesters.

---
 rtl/addr4u_share_ctrl.sv | 178 +++++++++++++++++
 tb/tb_addr4u_share_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/addr4u_share_ctrl.sv
// Round-robin share of one 4-bit adder between NREQ requesters.
// Each operand pair is evaluated as A+B and then B+A; disagreement triggers bounded retry.
module addr4u_share_ctrl #(
    parameter int NREQ      = 4,
    parameter int MAX_RETRY = 1,
    parameter int CNT_W     = 8,
    localparam int IDW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [4*NREQ-1:0] req_a,
    input  logic [4*NREQ-1:0] req_b,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [4:0]        resp_sum,
    output logic [IDW-1:0]    resp_id,
    output logic              resp_err,
    output logic [3:0]        add_a,
    output logic [3:0]        add_b,
    input  logic [4:0]        add_s,
    output logic [CNT_W-1:0]  fault_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAL1 = 2'd1,
        EVAL2 = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state, state_n;

    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  id_q;
    logic [3:0]      op_a;
    logic [3:0]      op_b;
    logic [4:0]      s1;
    logic            err_q;
    logic [2:0]      retry;

    logic            grant_hit;
    logic [IDW-1:0]  grant_id;
    logic [NREQ-1:0] grant_oh;
    logic [IDW:0]    cand;
    logic [IDW-1:0]  ptr_n;
    logic            hs;

    logic            latch;
    logic            cap_s1;
    logic            fault_inc;
    logic            retry_inc;
    logic            set_err;
    logic            resp_done;

    // First asserted requester at or after the pointer, wrapping at NREQ.
    always_comb begin
        grant_hit = 1'b0;
        grant_id  = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ))
                cand = cand - (IDW+1)'(NREQ);
            if (!grant_hit && req_valid[cand[IDW-1:0]]) begin
                grant_hit = 1'b1;
                grant_id  = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        grant_oh = '0;
        if (grant_hit)
            grant_oh[grant_id] = 1'b1;
    end

    assign req_ready = (state == IDLE && !rst) ? grant_oh : '0;
    assign hs        = |req_ready;
    assign ptr_n     = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;

    always_comb begin
        state_n   = state;
        latch     = 1'b0;
        cap_s1    = 1'b0;
        fault_inc = 1'b0;
        retry_inc = 1'b0;
        set_err   = 1'b0;
        resp_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (hs) begin
                    latch   = 1'b1;
                    state_n = EVAL1;
                end
            end
            EVAL1: begin
                cap_s1  = 1'b1;
                state_n = EVAL2;
            end
            EVAL2: begin
                if (add_s == s1) begin
                    state_n = RESP;
                end else begin
                    fault_inc = 1'b1;
                    if (retry < 3'(MAX_RETRY)) begin
                        retry_inc = 1'b1;
                        state_n   = EVAL1;
                    end else begin
                        set_err = 1'b1;
                        state_n = RESP;
                    end
                end
            end
            RESP: begin
                if (resp_ready) begin
                    resp_done = 1'b1;
                    state_n   = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            id_q      <= '0;
            op_a      <= '0;
            op_b      <= '0;
            s1        <= '0;
            err_q     <= 1'b0;
            retry     <= '0;
            fault_cnt <= '0;
        end else begin
            state <= state_n;
            if (latch) begin
                op_a  <= req_a[4*grant_id +: 4];
                op_b  <= req_b[4*grant_id +: 4];
                id_q  <= grant_id;
                ptr   <= ptr_n;
                err_q <= 1'b0;
                retry <= '0;
            end
            if (cap_s1)
                s1 <= add_s;
            if (fault_inc && fault_cnt != {CNT_W{1'b1}})
                fault_cnt <= fault_cnt + 1'b1;
            if (retry_inc)
                retry <= retry + 1'b1;
            if (set_err)
                err_q <= 1'b1;
            if (resp_done)
                retry <= '0;
        end
    end

    // Second evaluation swaps the operands so a non-commutative fault shows up.
    always_comb begin
        add_a = 4'd0;
        add_b = 4'd0;
        if (state == EVAL1) begin
            add_a = op_a;
            add_b = op_b;
        end else if (state == EVAL2) begin
            add_a = op_b;
            add_b = op_a;
        end
    end

    assign resp_valid = (state == RESP);
    assign resp_sum   = resp_valid ? s1 : 5'd0;
    assign resp_id    = resp_valid ? id_q : '0;
    assign resp_err   = resp_valid ? err_q : 1'b0;

endmodule

// File: tb/tb_addr4u_share_ctrl.sv
// Directed bench for addr4u_share_ctrl with a behavioural adder
// that can be made faulty (non-commutative, or one-shot corrupted).
module tb_addr4u_share_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [15:0] req_a = '0;
    logic [15:0] req_b = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [4:0]  resp_sum;
    logic [1:0]  resp_id;
    logic        resp_err;
    logic [3:0]  add_a;
    logic [3:0]  add_b;
    logic [4:0]  add_s;
    logic [7:0]  fault_cnt;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   mode  = 0;
    logic corrupt = 1'b0;

    addr4u_share_ctrl #(.NREQ(4), .MAX_RETRY(1), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_sum(resp_sum), .resp_id(resp_id), .resp_err(resp_err),
        .add_a(add_a), .add_b(add_b), .add_s(add_s),
        .fault_cnt(fault_cnt)
    );

    always #5 clk = ~clk;

    // mode 1: adds one when a > b, so A+B != B+A whenever A != B
    always_comb begin
        add_s = {1'b0, add_a} + {1'b0, add_b};
        if (mode == 1 && add_a > add_b)
            add_s = add_s + 5'd1;
        if (corrupt)
            add_s = add_s ^ 5'd1;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        req_valid = '0;
        resp_ready = 1'b1;
        corrupt = 1'b0;
        step;
        step;
        rst = 1'b0;
        #1;
    endtask

    // lat counts edges after the request handshake edge until resp_valid is seen
    task automatic txn(input int idx, input logic [3:0] a, input logic [3:0] b,
                       input bit corrupt_first,
                       output int sum, output int id, output int err, output int lat);
        int n;
        req_a[4*idx +: 4] = a;
        req_b[4*idx +: 4] = b;
        req_valid[idx] = 1'b1;
        #1;
        n = 0;
        while (!req_ready[idx] && n < 20) begin
            step;
            n++;
        end
        sum = -1; id = -1; err = -1; lat = -1;
        if (!req_ready[idx]) begin
            chk("grant_timeout", 0, 1);
            req_valid[idx] = 1'b0;
            return;
        end
        step;
        req_valid[idx] = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 30) begin
            step;
            lat++;
            corrupt = corrupt_first && (lat == 1);
        end
        corrupt = 1'b0;
        if (!resp_valid) begin
            chk("resp_timeout", 0, 1);
            return;
        end
        sum = resp_sum;
        id  = resp_id;
        err = resp_err;
        step;
    endtask

    typedef struct {
        int         idx;
        logic [3:0] a;
        logic [3:0] b;
        int         sum;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int sum, id, err, lat, g;
        int order[$];
        bit seen;
        logic [4:0]  h_sum;

        vecs[0] = '{0, 4'd9,  4'd7,  16};
        vecs[1] = '{1, 4'd15, 4'd15, 30};
        vecs[2] = '{2, 4'd0,  4'd0,  0};
        vecs[3] = '{3, 4'd8,  4'd8,  16};
        vecs[4] = '{1, 4'd15, 4'd1,  16};
        vecs[5] = '{2, 4'd5,  4'd10, 15};

        // reset state, with a request pending during reset
        rst = 1'b1;
        req_valid = 4'b0001;
        #2;
        chk("rst_req_ready", int'(req_ready), 0);
        req_valid = '0;
        do_reset;
        chk("rst_resp_valid", int'(resp_valid), 0);
        chk("rst_resp_sum", int'(resp_sum), 0);
        chk("rst_add_a", int'(add_a), 0);
        chk("rst_add_b", int'(add_b), 0);
        chk("rst_fault_cnt", int'(fault_cnt), 0);
        chk("rst_req_ready_idle", int'(req_ready), 0);

        // single requests, good adder
        for (int i = 0; i < 6; i++) begin
            txn(vecs[i].idx, vecs[i].a, vecs[i].b, 1'b0, sum, id, err, lat);
            chk($sformatf("vec%0d_sum", i), sum, vecs[i].sum);
            chk($sformatf("vec%0d_id", i), id, vecs[i].idx);
            chk($sformatf("vec%0d_err", i), err, 0);
            chk($sformatf("vec%0d_lat", i), lat, 2);
        end
        chk("good_fault_cnt", int'(fault_cnt), 0);

        // round robin with all requesters valid
        do_reset;
        req_a = 16'h3210;
        req_b = 16'h4321;
        req_valid = 4'hF;
        #1;
        for (int c = 0; c < 80 && order.size() < 5; c++) begin
            if (|req_ready) begin
                chk("rr_onehot", int'($onehot(req_ready)), 1);
                g = 0;
                for (int i = 0; i < 4; i++)
                    if (req_ready[i]) g = i;
                order.push_back(g);
            end
            if (resp_valid)
                chk("rr_sum", int'(resp_sum), 2 * int'(resp_id) + 1);
            step;
        end
        chk("rr_count", order.size(), 5);
        for (int k = 0; k < order.size(); k++)
            chk($sformatf("rr_order%0d", k), order[k], k % 4);

        // one-shot corruption of the first B+A, recovered by retry
        do_reset;
        txn(1, 4'd6, 4'd9, 1'b1, sum, id, err, lat);
        chk("c1_sum", sum, 15);
        chk("c1_err", err, 0);
        chk("c1_lat", lat, 4);
        chk("c1_fault_cnt", int'(fault_cnt), 1);

        // persistent non-commutative fault
        do_reset;
        mode = 1;
        txn(2, 4'd3, 4'd12, 1'b0, sum, id, err, lat);
        mode = 0;
        chk("stuck_sum", sum, 15);
        chk("stuck_id", id, 2);
        chk("stuck_err", err, 1);
        chk("stuck_lat", lat, 4);
        chk("stuck_fault_cnt", int'(fault_cnt), 2);

        // response back-pressure
        do_reset;
        resp_ready = 1'b0;
        req_a[3:0] = 4'd5;
        req_b[3:0] = 4'd4;
        req_valid[0] = 1'b1;
        #1;
        chk("bp_grant0", int'(req_ready), 1);
        step;
        req_valid[0] = 1'b0;
        req_a[15:12] = 4'd2;
        req_b[15:12] = 4'd3;
        req_valid[3] = 1'b1;
        for (int n = 0; n < 10 && !resp_valid; n++)
            step;
        for (int n = 0; n < 5; n++) begin
            chk("bp_valid", int'(resp_valid), 1);
            chk("bp_sum", int'(resp_sum), 9);
            chk("bp_id", int'(resp_id), 0);
            chk("bp_err", int'(resp_err), 0);
            chk("bp_no_grant", int'(req_ready), 0);
            step;
        end
        resp_ready = 1'b1;
        step;
        chk("bp_after_valid", int'(resp_valid), 0);
        chk("bp_after_grant3", int'(req_ready), 8);

        // reset while in EVAL2
        do_reset;
        mode = 1;
        txn(0, 4'd1, 4'd2, 1'b0, sum, id, err, lat);
        mode = 0;
        chk("pre_rst_fault_cnt", int'(fault_cnt), 2);
        req_a[7:4] = 4'd7;
        req_b[7:4] = 4'd2;
        req_valid[1] = 1'b1;
        #1;
        step;
        req_valid[1] = 1'b0;
        step;
        chk("eval2_add_a", int'(add_a), 2);
        chk("eval2_add_b", int'(add_b), 7);
        rst = 1'b1;
        #1;
        chk("mid_rst_add_a", int'(add_a), 0);
        chk("mid_rst_add_b", int'(add_b), 0);
        chk("mid_rst_fault_cnt", int'(fault_cnt), 0);
        chk("mid_rst_resp_valid", int'(resp_valid), 0);
        step;
        rst = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 8; n++) begin
            step;
            if (resp_valid) seen = 1'b1;
        end
        chk("mid_rst_no_resp", int'(seen), 0);

        // fault counter saturation
        do_reset;
        mode = 1;
        for (int t = 0; t < 127; t++)
            txn(0, 4'd1, 4'd2, 1'b0, sum, id, err, lat);
        chk("sat_254", int'(fault_cnt), 254);
        txn(0, 4'd1, 4'd2, 1'b0, sum, id, err, lat);
        chk("sat_255", int'(fault_cnt), 255);
        txn(0, 4'd1, 4'd2, 1'b0, sum, id, err, lat);
        chk("sat_hold", int'(fault_cnt), 255);
        h_sum = 5'(sum);
        chk("sat_sum", int'(h_sum), 3);
        chk("sat_err", err, 1);
        mode = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
